// File: rtl/jt03_snd_mix.sv
// Post-mixer for the YM2203 wrapper. It scales the FM and PSG outputs through one shared multiplier,
// removes the PSG DC offset with a leaky integrator, and saturates the sum to a signed 16-bit sample.
module jt03_snd_mix #(
    parameter int unsigned DC_EN    = 1,
    parameter int unsigned DC_SHIFT = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_snd_sample,
    input  logic [15:0] i_fm_snd,
    input  logic [7:0]  i_psg_a,
    input  logic [7:0]  i_psg_b,
    input  logic [7:0]  i_psg_c,
    input  logic [7:0]  i_fm_gain,
    input  logic [7:0]  i_psg_gain,
    input  logic        i_mute,
    output logic [15:0] o_mix,
    output logic        o_mix_valid,
    output logic        o_clip,
    output logic        o_overrun
);

    localparam int unsigned DcW = 10 + DC_SHIFT;

    typedef enum logic [2:0] {
        StIdle,
        StDc,
        StMfm,
        StMpsg,
        StOut
    } state_t;

    state_t r_state;
    state_t w_state_d;

    logic [15:0]        r_fm;
    logic [9:0]         r_psg_sum;
    logic signed [10:0] r_psg_ac;
    logic [DcW-1:0]     r_dc_acc;
    logic signed [25:0] r_acc;
    logic [15:0]        r_mix;
    logic               r_mix_valid;
    logic               r_clip;
    logic               r_overrun;

    logic [9:0]         w_psg_sum;
    logic [9:0]         w_dc;
    logic [DcW-1:0]     w_dc_acc_d;
    logic signed [10:0] w_psg_ac;
    logic signed [25:0] w_mul_a;
    logic signed [25:0] w_mul_b;
    logic signed [25:0] w_prod;
    logic               w_sat_hi;
    logic               w_sat_lo;
    logic [15:0]        w_clamped;

    assign w_psg_sum = {2'b00, i_psg_a} + {2'b00, i_psg_b} + {2'b00, i_psg_c};

    // The integrator settles at psg_sum << DC_SHIFT, so the estimate always fits in 10 bits.
    assign w_dc       = r_dc_acc[DcW-1:DC_SHIFT];
    assign w_dc_acc_d = r_dc_acc + {{DC_SHIFT{1'b0}}, r_psg_sum} - {{DC_SHIFT{1'b0}}, w_dc};

    assign w_psg_ac = (DC_EN != 0) ? $signed({1'b0, r_psg_sum}) - $signed({1'b0, w_dc})
                                   : $signed({1'b0, r_psg_sum});

    // One multiplier: FM operands in StMfm, PSG operands in StMpsg.
    always_comb begin
        w_mul_a = {{10{r_fm[15]}}, r_fm};
        w_mul_b = {18'd0, i_fm_gain};
        if (r_state == StMpsg) begin
            w_mul_a = {{15{r_psg_ac[10]}}, r_psg_ac};
            w_mul_b = {18'd0, i_psg_gain};
        end
    end

    assign w_prod = w_mul_a * w_mul_b;

    assign w_sat_hi  = r_acc > 26'sd32767;
    assign w_sat_lo  = r_acc < -26'sd32768;
    assign w_clamped = w_sat_hi ? 16'h7fff : (w_sat_lo ? 16'h8000 : r_acc[15:0]);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_snd_sample) w_state_d = StDc;
            StDc:    w_state_d = StMfm;
            StMfm:   w_state_d = StMpsg;
            StMpsg:  w_state_d = StOut;
            StOut:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fm        <= '0;
            r_psg_sum   <= '0;
            r_psg_ac    <= '0;
            r_dc_acc    <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
            r_clip      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            r_clip      <= 1'b0;
            if (i_snd_sample && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (i_snd_sample) begin
                        r_fm      <= i_fm_snd;
                        r_psg_sum <= w_psg_sum;
                    end
                end
                StDc: begin
                    r_psg_ac <= w_psg_ac;
                    if (DC_EN != 0) begin
                        r_dc_acc <= w_dc_acc_d;
                    end
                end
                StMfm: begin
                    r_acc <= w_prod >>> 4;
                end
                StMpsg: begin
                    r_acc <= r_acc + (w_prod <<< 2);
                end
                StOut: begin
                    r_mix_valid <= 1'b1;
                    if (i_mute) begin
                        r_mix <= '0;
                    end else begin
                        r_mix  <= w_clamped;
                        r_clip <= w_sat_hi | w_sat_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mix       = r_mix;
    assign o_mix_valid = r_mix_valid;
    assign o_clip      = r_clip;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_jt03_snd_mix.sv
// Scoreboard bench for jt03_snd_mix: two instances (DC removal off / on) share stimulus,
// an arithmetic model queues expected samples, and a negedge monitor pops them on each valid.
module tb_jt03_snd_mix;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snd;
    logic [15:0] fm;
    logic [7:0]  pa, pb, pc, fg, pg;
    logic        mute;

    logic [15:0] mix0, mix1;
    logic        v0, v1, clip0, clip1, ov0, ov1;

    always #5 clk = ~clk;

    jt03_snd_mix #(.DC_EN(0), .DC_SHIFT(6)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_snd_sample(snd), .i_fm_snd(fm),
        .i_psg_a(pa), .i_psg_b(pb), .i_psg_c(pc), .i_fm_gain(fg), .i_psg_gain(pg),
        .i_mute(mute), .o_mix(mix0), .o_mix_valid(v0), .o_clip(clip0), .o_overrun(ov0)
    );

    jt03_snd_mix #(.DC_EN(1), .DC_SHIFT(4)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_snd_sample(snd), .i_fm_snd(fm),
        .i_psg_a(pa), .i_psg_b(pb), .i_psg_c(pc), .i_fm_gain(fg), .i_psg_gain(pg),
        .i_mute(mute), .o_mix(mix1), .o_mix_valid(v1), .o_clip(clip1), .o_overrun(ov1)
    );

    typedef struct {
        longint mix;
        logic   clip;
        longint due;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    longint dc0, dc1;
    longint last_edge;
    logic   m_ov;
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Behavioural reference: whole-sample arithmetic straight from the mixing rules.
    task automatic model(input int dc_en, input int shift, input longint f, input longint a,
                         input longint b, input longint c, input longint fgain,
                         input longint pgain, input logic mt, inout longint dcacc,
                         output exp_t e);
        longint sum, dc, ac, v;
        sum = a + b + c;
        if (dc_en != 0) begin
            dc    = dcacc / (longint'(1) << shift);
            ac    = sum - dc;
            dcacc = dcacc + sum - dc;
        end else begin
            ac = sum;
        end
        v = ((f * fgain) >>> 4) + ac * pgain * 4;
        e.due = 0;
        if (mt) begin
            e.mix = 0;
            e.clip = 1'b0;
        end else if (v > 32767) begin
            e.mix = 32767;
            e.clip = 1'b1;
        end else if (v < -32768) begin
            e.mix = -32768;
            e.clip = 1'b1;
        end else begin
            e.mix = v;
            e.clip = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] fgain, input logic [7:0] pgain,
                        input logic mt, input int gap);
        exp_t   e;
        longint e_edge;
        longint fs;
        @(negedge clk);
        fm = f; pa = a; pb = b; pc = c; fg = fgain; pg = pgain; mute = mt;
        snd = 1'b1;
        e_edge = cyc + 1;
        fs = longint'($signed(f));
        if (rst_n && (e_edge >= last_edge + 5)) begin
            last_edge = e_edge;
            model(0, 6, fs, a, b, c, fgain, pgain, mt, dc0, e);
            e.due = e_edge + 4;
            q0.push_back(e);
            model(1, 4, fs, a, b, c, fgain, pgain, mt, dc1, e);
            e.due = e_edge + 4;
            q1.push_back(e);
        end else if (rst_n) begin
            m_ov = 1'b1;
        end
        @(negedge clk);
        snd = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic pop_chk(input int id, input logic [15:0] m, input logic cl);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d_unexpected_valid: got mix=%0d at cycle %0d, expected no valid",
                     id, $signed(m), cyc);
        end else begin
            if (id == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("dut%0d_mix", id), longint'($signed(m)), e.mix);
            chk($sformatf("dut%0d_clip", id), longint'(cl), longint'(e.clip));
            chk($sformatf("dut%0d_latency", id), cyc, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (v0) pop_chk(0, mix0, clip0);
        if (v1) pop_chk(1, mix1, clip1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; snd = 1'b1; fm = 16'd0; pa = 8'd0; pb = 8'd0; pc = 8'd0;
        fg = 8'h10; pg = 8'h10; mute = 1'b0;
        last_edge = -100; m_ov = 1'b0; dc0 = 0; dc1 = 0;
        // Strobe held during reset must be ignored.
        repeat (2) @(negedge clk);
        snd = 1'b0;
        @(negedge clk);
        chk("dut0_rst_mix", longint'(mix0), 0);
        chk("dut0_rst_valid", longint'(v0), 0);
        chk("dut0_rst_clip", longint'(clip0), 0);
        chk("dut0_rst_overrun", longint'(ov0), 0);
        chk("dut1_rst_mix", longint'(mix1), 0);
        chk("dut1_rst_valid", longint'(v1), 0);
        chk("dut1_rst_clip", longint'(clip1), 0);
        chk("dut1_rst_overrun", longint'(ov1), 0);
        rst_n = 1'b1;

        send(16'd1000, 8'd0, 8'd0, 8'd0, 8'h10, 8'h10, 1'b0, 6);
        send(16'h7fff, 8'd0, 8'd0, 8'd0, 8'h20, 8'h10, 1'b0, 5);
        send(16'h8000, 8'd0, 8'd0, 8'd0, 8'hff, 8'h10, 1'b0, 5);
        repeat (10) send(16'd0, 8'd100, 8'd100, 8'd100, 8'h10, 8'h10, 1'b0, 5);
        send(16'd12345, 8'd50, 8'd60, 8'd70, 8'h10, 8'h10, 1'b1, 5);

        for (int i = 0; i < 40; i++) begin
            send(16'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 64)),
                 8'($urandom_range(0, 40)), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(5, 8)));
        end
        chk("dut0_overrun_idle", longint'(ov0), longint'(m_ov));
        chk("dut1_overrun_idle", longint'(ov1), longint'(m_ov));

        // Second strobe 3 clk after the first is dropped.
        send(16'd100, 8'd1, 8'd2, 8'd3, 8'h10, 8'h10, 1'b0, 3);
        send(16'd200, 8'd4, 8'd5, 8'd6, 8'h10, 8'h10, 1'b0, 5);
        send(16'd300, 8'd7, 8'd8, 8'd9, 8'h10, 8'h10, 1'b0, 6);
        chk("dut0_overrun_set", longint'(ov0), longint'(m_ov));
        chk("dut1_overrun_set", longint'(ov1), longint'(m_ov));
        send(16'd400, 8'd9, 8'd9, 8'd9, 8'h10, 8'h10, 1'b0, 6);
        chk("dut0_overrun_sticky", longint'(ov0), longint'(m_ov));
        chk("dut1_overrun_sticky", longint'(ov1), longint'(m_ov));

        // Reset for one clk while the sample is in the FM multiply step.
        send(16'd500, 8'd10, 8'd10, 8'd10, 8'h10, 8'h10, 1'b0, 2);
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        dc0 = 0; dc1 = 0; m_ov = 1'b0; last_edge = -100;
        @(negedge clk);
        rst_n = 1'b1;
        chk("dut0_midrst_mix", longint'(mix0), 0);
        chk("dut0_midrst_valid", longint'(v0), 0);
        chk("dut0_midrst_overrun", longint'(ov0), longint'(m_ov));
        chk("dut1_midrst_mix", longint'(mix1), 0);
        chk("dut1_midrst_valid", longint'(v1), 0);
        chk("dut1_midrst_overrun", longint'(ov1), longint'(m_ov));
        repeat (8) @(negedge clk);
        repeat (3) send(16'd0, 8'd100, 8'd100, 8'd100, 8'h10, 8'h10, 1'b0, 5);
        send(16'd777, 8'd20, 8'd20, 8'd20, 8'h18, 8'h08, 1'b1, 5);

        repeat (8) @(negedge clk);
        chk("dut0_drain", longint'(q0.size()), 0);
        chk("dut1_drain", longint'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
